// File: rtl/alu_reservation_station.sv
// alu_reservation_station
//   Integer ALU reservation station for the Tomasulo core. Buffers up to DEPTH
//   ALU micro-ops, captures pending operands from two CDB ports (including in
//   the issue cycle), and each cycle executes the oldest entry whose operands
//   are ready, broadcasting one registered result with its ROB tag.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   flush                   synchronous clear of every entry and the result strobe
//   issue_valid/ready       issue handshake; ready while a free entry exists
//   issue_rob/op/funct3/flag destination tag, opcode, ALU subtype, sub/sra select
//   issue_data1/2, issue_q1/2 operand values and producer tags (NO_TAG = present)
//   cdb0_*, cdb1_*          two CDB broadcast ports (valid, tag, data)
//   out_valid/rob/data      one-cycle registered result strobe with ROB tag
//   count                   number of busy entries
module alu_reservation_station #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter logic [TAG_W-1:0] NO_TAG = TAG_W'(16)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  logic [TAG_W-1:0]            issue_rob,
    input  logic [6:0]                  issue_op,
    input  logic [2:0]                  issue_funct3,
    input  logic                        issue_flag,
    input  logic [DATA_W-1:0]           issue_data1,
    input  logic [DATA_W-1:0]           issue_data2,
    input  logic [TAG_W-1:0]            issue_q1,
    input  logic [TAG_W-1:0]            issue_q2,
    input  logic                        cdb0_valid,
    input  logic [TAG_W-1:0]            cdb0_tag,
    input  logic [DATA_W-1:0]           cdb0_data,
    input  logic                        cdb1_valid,
    input  logic [TAG_W-1:0]            cdb1_tag,
    input  logic [DATA_W-1:0]           cdb1_data,
    output logic                        out_valid,
    output logic [TAG_W-1:0]            out_rob,
    output logic [DATA_W-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0]  count
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int SH_W  = $clog2(DATA_W);

    // Capture an operand from the CDB; cdb0 has priority over cdb1.
    function automatic logic [TAG_W+DATA_W-1:0] capture(input logic [TAG_W-1:0]  q,
                                                        input logic [DATA_W-1:0] d);
        if (q != NO_TAG && cdb0_valid && cdb0_tag == q)
            return {NO_TAG, cdb0_data};
        else if (q != NO_TAG && cdb1_valid && cdb1_tag == q)
            return {NO_TAG, cdb1_data};
        else
            return {q, d};
    endfunction

    function automatic logic [DATA_W-1:0] alu_result(input logic [2:0]        f3,
                                                     input logic              fl,
                                                     input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        logic [SH_W-1:0]          sh;
        logic [DATA_W-1:0]        r;
        sa = a;
        sb = b;
        sh = b[SH_W-1:0];
        case (f3)
            3'b000:  r = fl ? a - b : a + b;
            3'b001:  r = a << sh;
            3'b010:  r = (sa < sb) ? DATA_W'(1) : '0;
            3'b011:  r = (a < b) ? DATA_W'(1) : '0;
            3'b100:  r = a ^ b;
            3'b101:  r = fl ? DATA_W'(sa >>> sh) : a >> sh;
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    logic [DEPTH-1:0]  busy;
    logic [TAG_W-1:0]  rob    [DEPTH];
    logic [2:0]        funct3 [DEPTH];
    logic              flag   [DEPTH];
    logic [DATA_W-1:0] data1  [DEPTH];
    logic [DATA_W-1:0] data2  [DEPTH];
    logic [TAG_W-1:0]  q1     [DEPTH];
    logic [TAG_W-1:0]  q2     [DEPTH];
    // older[i][j] = 1 when entry i was issued before entry j. Only meaningful
    // between busy entries; a newly written entry overwrites its row and column.
    logic [DEPTH-1:0]  older  [DEPTH];

    logic [DATA_W-1:0] data1_n [DEPTH];
    logic [DATA_W-1:0] data2_n [DEPTH];
    logic [TAG_W-1:0]  q1_n    [DEPTH];
    logic [TAG_W-1:0]  q2_n    [DEPTH];

    logic [DEPTH-1:0]  ready_vec;
    logic [DEPTH-1:0]  oldest_vec;
    logic              sel_hit;
    logic [IDX_W-1:0]  sel_idx;
    logic [DATA_W-1:0] sel_res;
    logic [IDX_W-1:0]  free_idx;
    logic [CNT_W-1:0]  busy_cnt;
    logic              issue_alu;

    logic              vld_p1;
    logic [TAG_W-1:0]  rob_p1;
    logic [DATA_W-1:0] data_p1;

    always_comb begin
        busy_cnt = '0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            busy_cnt = busy_cnt + CNT_W'(busy[i]);
            if (!busy[i])
                free_idx = IDX_W'(i);
        end
    end

    assign issue_ready = (busy_cnt < CNT_W'(DEPTH));
    assign issue_alu   = issue_valid && issue_ready && !flush &&
                         (issue_op == 7'b0110011 || issue_op == 7'b0010011);

    // Oldest-ready selection: an entry wins if no other ready entry is older.
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            ready_vec[i] = busy[i] && (q1[i] == NO_TAG) && (q2[i] == NO_TAG);
        for (int i = 0; i < DEPTH; i++) begin
            oldest_vec[i] = ready_vec[i];
            for (int j = 0; j < DEPTH; j++)
                if (j != i && ready_vec[j] && older[j][i])
                    oldest_vec[i] = 1'b0;
        end
        sel_hit = 1'b0;
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (oldest_vec[i]) begin
                sel_hit = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign sel_res = alu_result(funct3[sel_idx], flag[sel_idx], data1[sel_idx], data2[sel_idx]);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            {q1_n[i], data1_n[i]} = capture(q1[i], data1[i]);
            {q2_n[i], data2_n[i]} = capture(q2[i], data2[i]);
        end
    end

    // ---- stage p0: entry payload and age order (state gated by busy) ----
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (issue_alu && free_idx == IDX_W'(i)) begin
                rob[i]               <= issue_rob;
                funct3[i]            <= issue_funct3;
                flag[i]              <= issue_flag;
                {q1[i], data1[i]}    <= capture(issue_q1, issue_data1);
                {q2[i], data2[i]}    <= capture(issue_q2, issue_data2);
                older[i]             <= '0;
            end else begin
                q1[i]    <= q1_n[i];
                data1[i] <= data1_n[i];
                q2[i]    <= q2_n[i];
                data2[i] <= data2_n[i];
                if (issue_alu)
                    older[i][free_idx] <= 1'b1;
            end
        end
    end

    // ---- stage p1: busy bits and registered result ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy    <= '0;
            vld_p1  <= 1'b0;
            rob_p1  <= NO_TAG;
            data_p1 <= '0;
        end else if (flush) begin
            busy   <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= sel_hit;
            if (sel_hit) begin
                busy[sel_idx] <= 1'b0;
                rob_p1        <= rob[sel_idx];
                data_p1       <= sel_res;
            end
            if (issue_alu)
                busy[free_idx] <= 1'b1;
        end
    end

    assign out_valid = vld_p1;
    assign out_rob   = rob_p1;
    assign out_data  = data_p1;
    assign count     = busy_cnt;
endmodule

// File: tb/tb_alu_reservation_station.sv
module tb_alu_reservation_station;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam logic [5:0] NO_TAG = 6'd16;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    logic clock, reset, flush;
    logic issue_valid, issue_ready;
    logic [5:0] issue_rob;
    logic [6:0] issue_op;
    logic [2:0] issue_funct3;
    logic issue_flag;
    logic [31:0] issue_data1, issue_data2;
    logic [5:0] issue_q1, issue_q2;
    logic cdb0_valid, cdb1_valid;
    logic [5:0] cdb0_tag, cdb1_tag;
    logic [31:0] cdb0_data, cdb1_data;
    logic out_valid;
    logic [5:0] out_rob;
    logic [31:0] out_data;
    logic [2:0] count;

    alu_reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .NO_TAG(NO_TAG)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rob(issue_rob),
        .issue_op(issue_op), .issue_funct3(issue_funct3), .issue_flag(issue_flag),
        .issue_data1(issue_data1), .issue_data2(issue_data2),
        .issue_q1(issue_q1), .issue_q2(issue_q2),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .out_valid(out_valid), .out_rob(out_rob), .out_data(out_data), .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  rob;
        logic [2:0]  f3;
        logic        fl;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  qa;
        logic [5:0]  qb;
    } ent_t;

    ent_t        rs[$];          // model station, oldest at the front
    logic        exp_vld;
    logic [5:0]  exp_rob;
    logic [31:0] exp_data;
    int          total;
    int          bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic fl,
                                            input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (f3)
            3'd0: return fl ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return fl ? ((a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0)) : (a >> sh);
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic void grab(inout logic [5:0] q, inout logic [31:0] d);
        if (q == NO_TAG) return;
        if (cdb0_valid && cdb0_tag == q) begin d = cdb0_data; q = NO_TAG; end
        else if (cdb1_valid && cdb1_tag == q) begin d = cdb1_data; q = NO_TAG; end
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        ent_t e;
        int   pick;
        logic fire;
        fire = issue_valid && (rs.size() < DEPTH) && !flush;
        if (flush) begin
            rs.delete();
            exp_vld = 1'b0;
            return;
        end
        pick = -1;
        foreach (rs[i])
            if (pick < 0 && rs[i].qa == NO_TAG && rs[i].qb == NO_TAG) pick = i;
        if (pick >= 0) begin
            exp_vld  = 1'b1;
            exp_rob  = rs[pick].rob;
            exp_data = ref_alu(rs[pick].f3, rs[pick].fl, rs[pick].a, rs[pick].b);
            rs.delete(pick);
        end else begin
            exp_vld = 1'b0;
        end
        foreach (rs[i]) begin
            e = rs[i];
            grab(e.qa, e.a);
            grab(e.qb, e.b);
            rs[i] = e;
        end
        if (fire && (issue_op == OP_R || issue_op == OP_I)) begin
            e.rob = issue_rob; e.f3 = issue_funct3; e.fl = issue_flag;
            e.a = issue_data1; e.b = issue_data2; e.qa = issue_q1; e.qb = issue_q2;
            grab(e.qa, e.a);
            grab(e.qb, e.b);
            rs.push_back(e);
        end
    endtask

    task automatic cycle();
        chk("issue_ready", issue_ready, rs.size() < DEPTH);
        chk("count", count, rs.size());
        model_step();
        @(posedge clock);
        #1;
        chk("out_valid", out_valid, exp_vld);
        chk("out_rob", out_rob, exp_rob);
        chk("out_data", out_data, exp_data);
    endtask

    task automatic idle();
        issue_valid = 1'b0; flush = 1'b0;
        cdb0_valid = 1'b0; cdb1_valid = 1'b0;
    endtask

    task automatic issue(input logic [5:0] rob, input logic [6:0] op, input logic [2:0] f3,
                         input logic fl, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] qa, input logic [5:0] qb);
        issue_valid = 1'b1; issue_rob = rob; issue_op = op; issue_funct3 = f3;
        issue_flag = fl; issue_data1 = a; issue_data2 = b; issue_q1 = qa; issue_q2 = qb;
    endtask

    task automatic model_reset();
        rs.delete();
        exp_vld = 1'b0; exp_rob = NO_TAG; exp_data = 32'h0;
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1;
        idle();
        issue_rob = 0; issue_op = OP_R; issue_funct3 = 0; issue_flag = 0;
        issue_data1 = 0; issue_data2 = 0; issue_q1 = NO_TAG; issue_q2 = NO_TAG;
        cdb0_tag = 0; cdb1_tag = 0; cdb0_data = 0; cdb1_data = 0;
        model_reset();
        #23;
        chk("rst_valid", out_valid, 0);
        chk("rst_rob", out_rob, NO_TAG);
        chk("rst_data", out_data, 0);
        chk("rst_count", count, 0);
        chk("rst_ready", issue_ready, 1);
        reset = 1'b0;
        #9;

        // add with both operands present
        issue(6'd3, OP_R, 3'd0, 1'b0, 32'd5, 32'd7, NO_TAG, NO_TAG);
        cycle();
        idle();
        cycle();
        chk("add_valid", out_valid, 1);
        chk("add_rob", out_rob, 3);
        chk("add_data", out_data, 12);
        cycle();
        chk("add_pulse", out_valid, 0);
        chk("add_count", count, 0);

        // sub waiting on tag 9 via cdb1
        issue(6'd1, OP_R, 3'd0, 1'b1, 32'd0, 32'd4, 6'd9, NO_TAG);
        cycle();
        idle();
        cdb1_valid = 1'b1; cdb1_tag = 6'd9; cdb1_data = 32'd20;
        cycle();
        chk("sub_wait", out_valid, 0);
        idle();
        cycle();
        chk("sub_valid", out_valid, 1);
        chk("sub_data", out_data, 16);

        // same, broadcast in the issue cycle
        issue(6'd1, OP_R, 3'd0, 1'b1, 32'd0, 32'd4, 6'd9, NO_TAG);
        cdb1_valid = 1'b1; cdb1_tag = 6'd9; cdb1_data = 32'd20;
        cycle();
        idle();
        cycle();
        chk("byp_valid", out_valid, 1);
        chk("byp_data", out_data, 16);

        // srai, sltu, slt back to back
        issue(6'd2, OP_I, 3'd5, 1'b1, 32'h8000_0000, 32'h24, NO_TAG, NO_TAG);
        cycle();
        issue(6'd4, OP_R, 3'd3, 1'b0, 32'd1, 32'hFFFF_FFFF, NO_TAG, NO_TAG);
        cycle();
        chk("srai_data", out_data, 32'hF800_0000);
        issue(6'd5, OP_R, 3'd2, 1'b0, 32'd1, 32'hFFFF_FFFF, NO_TAG, NO_TAG);
        cycle();
        chk("sltu_data", out_data, 1);
        idle();
        cycle();
        chk("slt_rob", out_rob, 5);
        chk("slt_data", out_data, 0);

        // fill all entries waiting on tag 5, then one ignored issue
        for (int k = 0; k < DEPTH; k++) begin
            issue(6'(8 + k), OP_R, 3'd0, 1'b0, 32'd0, 32'(k), 6'd5, NO_TAG);
            cycle();
        end
        chk("full_ready", issue_ready, 0);
        issue(6'd12, OP_R, 3'd0, 1'b0, 32'd1, 32'd1, NO_TAG, NO_TAG);
        cycle();
        idle();
        cdb0_valid = 1'b1; cdb0_tag = 6'd5; cdb0_data = 32'd1000;
        cycle();
        idle();
        for (int k = 0; k < DEPTH; k++) begin
            cycle();
            chk("full_rob", out_rob, 8 + k);
            chk("full_data", out_data, 1000 + k);
        end
        cycle();
        chk("full_drained", out_valid, 0);

        // flush with three busy entries and a concurrent issue
        for (int k = 0; k < 3; k++) begin
            issue(6'(k), OP_R, 3'd6, 1'b0, 32'd1, 32'd2, 6'd7, NO_TAG);
            cycle();
        end
        issue(6'd13, OP_R, 3'd0, 1'b0, 32'd1, 32'd1, NO_TAG, NO_TAG);
        flush = 1'b1;
        cycle();
        chk("flush_count", count, 0);
        idle();
        cdb0_valid = 1'b1; cdb0_tag = 6'd7; cdb0_data = 32'd3;
        cycle();
        idle();
        repeat (3) begin
            cycle();
            chk("flush_quiet", out_valid, 0);
        end

        // asynchronous reset while a result is showing and an entry waits
        issue(6'd6, OP_R, 3'd4, 1'b0, 32'd3, 32'd5, NO_TAG, NO_TAG);
        cycle();
        issue(6'd7, OP_R, 3'd0, 1'b0, 32'd1, 32'd1, 6'd9, NO_TAG);
        cycle();
        chk("pre_rst_data", out_data, 6);
        idle();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_rob", out_rob, NO_TAG);
        chk("arst_data", out_data, 0);
        chk("arst_count", count, 0);
        chk("arst_ready", issue_ready, 1);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        issue(6'd11, OP_R, 3'd1, 1'b0, 32'd3, 32'd4, NO_TAG, NO_TAG);
        cycle();
        idle();
        cycle();
        chk("post_rst_data", out_data, 48);

        // randomized traffic against the model
        repeat (600) begin
            idle();
            issue_valid  = ($urandom_range(0, 3) != 0);
            issue_rob    = 6'($urandom_range(0, 15));
            issue_op     = ($urandom_range(0, 9) == 0) ? 7'b0000011 :
                           (($urandom_range(0, 1) == 0) ? OP_R : OP_I);
            issue_funct3 = 3'($urandom_range(0, 7));
            issue_flag   = 1'($urandom_range(0, 1));
            issue_data1  = $urandom;
            issue_data2  = $urandom;
            issue_q1     = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 15)) : NO_TAG;
            issue_q2     = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 15)) : NO_TAG;
            cdb0_valid   = 1'($urandom_range(0, 1));
            cdb0_tag     = 6'($urandom_range(0, 15));
            cdb0_data    = $urandom;
            cdb1_valid   = 1'($urandom_range(0, 1));
            cdb1_tag     = ($urandom_range(0, 3) == 0) ? cdb0_tag : 6'($urandom_range(0, 15));
            cdb1_data    = $urandom;
            flush        = ($urandom_range(0, 40) == 0);
            cycle();
        end
        idle();
        repeat (8) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

Parametrised ALU reservation station for the Tomasulo out-of-order core. It sits between the issue/rename stage and the common data bus (CDB). It buffers up to DEPTH integer ALU micro-ops (opcodes 0110011 / 0010011) and captures pending operands from two CDB ports, including in the issue cycle. Each cycle it executes the oldest entry whose operands are ready and broadcasts one registered result with its ROB tag. Unlike the previous fixed 4-entry station, it uses a valid/ready issue handshake, oldest-first selection, a synchronous flush and a fully clocked CDB capture path.

## Interface
Parameters:
- DEPTH, 4, number of entries (2..16)
- TAG_W, 6, ROB tag width
- DATA_W, 32, operand/result width
- NO_TAG, 6'd16, tag value meaning "operand present"; valid ROB tags are 0..15

Ports:
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- flush  in  1  synchronous mispredict clear of all entries
- issue_valid  in  1  issue request
- issue_ready  out  1  at least one free entry
- issue_rob  in  TAG_W  destination ROB tag
- issue_op  in  7  opcode
- issue_funct3  in  3  subtype
- issue_flag  in  1  sub / sra select
- issue_data1, issue_data2  in  DATA_W  operand values (valid when matching q = NO_TAG)
- issue_q1, issue_q2  in  TAG_W  producer tags, or NO_TAG
- cdb0_valid, cdb1_valid  in  1  CDB broadcast strobes
- cdb0_tag, cdb1_tag  in  TAG_W  broadcast ROB tags
- cdb0_data, cdb1_data  in  DATA_W  broadcast values
- out_valid  out  1  result strobe (one cycle)
- out_rob  out  TAG_W  result ROB tag
- out_data  out  DATA_W  result value
- count  out  $clog2(DEPTH+1)  number of busy entries

## Operation
- Each entry holds: busy, rob, op, funct3, flag, data1, data2, q1, q2 and an age rank.
- Issue:
  - Accepted at an edge when issue_valid & issue_ready & !flush.
  - issue_ready = (count < DEPTH), derived from registered state only. An entry freed in the same cycle does not raise issue_ready.
  - If issue_op is not 0110011 or 0010011, the handshake completes but nothing is written.
  - The new op goes into the lowest-index free entry and is ranked youngest.
- CDB capture, every edge, for each busy entry and for the operands being issued:
  - If qX == cdbN_tag, cdbN_valid = 1 and qX != NO_TAG, then dataX := cdbN_data and qX := NO_TAG.
  - If both ports match the same qX, cdb0 wins.
  - Issue-cycle bypass is mandatory: an operand whose producer broadcasts in the issue cycle is stored as ready.
- Select and execute:
  - An entry is ready when busy and q1 == q2 == NO_TAG in registered state.
  - The oldest ready entry is chosen. At the edge it frees that entry and registers out_valid = 1, out_rob = rob and out_data = result.
  - Operands captured from the CDB this edge make the entry eligible from the next cycle.
  - If no entry is ready, out_valid = 0; out_rob and out_data hold their previous values.
- Result by funct3 (sh = data2[$clog2(DATA_W)-1:0]):
  - 000: data1 + data2, or data1 - data2 when flag = 1
  - 001: data1 << sh
  - 010: signed data1 < data2 ? 1 : 0
  - 011: unsigned compare, same form as 010
  - 100: XOR
  - 101: logical >> sh, or arithmetic >>> sh when flag = 1
  - 110: OR
  - 111: AND
  - All arithmetic wraps modulo 2^DATA_W.
- Flush:
  - At the edge, clears every busy bit.
  - Forces out_valid = 0.
  - Drops any issue presented in that cycle.
  - count = 0 after the edge.

## Timing
- Reset values, asynchronous: all busy = 0, count = 0, issue_ready = 1, out_valid = 0, out_rob = NO_TAG, out_data = 0.
- Reset asserted mid-operation discards all entries and any pending result. Issue is accepted on the first edge after deassertion.
- Latency, issue with both operands ready: issue at edge k; out_valid is high after edge k+1.
- Latency, waiting operand: CDB broadcast at edge k; out_valid at the earliest after edge k+1.
- Throughput: one result per cycle, sustained.
- out_valid is a single-cycle pulse for each executed entry. Every accepted ALU op yields exactly one pulse unless flushed or reset.
- Full: at count == DEPTH, issue_ready = 0 and any issue_valid is ignored. Simultaneous issue and execute at count == DEPTH-1 ends with count == DEPTH-1.
- Age order is preserved across entry-index reuse. A freed low index refilled later is younger than every surviving entry.

## Test plan
- Reset, then issue add rob=3, d1=5, d2=7, both q = NO_TAG. Required: out_valid pulse one edge later with out_rob = 3, out_data = 12; count returns to 0.
- Issue sub rob=1, q1 = 9, d2 = 4, then broadcast cdb1 tag 9 data 20. Required: out_data = 16 exactly two edges after the broadcast edge (one edge to capture, one to execute). Repeat with the broadcast in the issue cycle: the result is 16, one edge earlier.
- Issue srai rob=2, d1 = 0x80000000, d2 = 0x24 (sh = 4). Required: out_data = 0xF8000000. Also check sltu 1 < 0xFFFFFFFF gives 1, and slt gives 0.
- Fill DEPTH entries all waiting on tag 5. Required: issue_ready = 0 and a further issue is ignored. Broadcast tag 5; required: DEPTH results emerge in issue order, one per cycle.
- Assert flush with 3 busy entries and a concurrent issue. Required: count = 0 and no out_valid afterward. Assert reset asynchronously between edges; required: outputs take reset values immediately.
